// File: rtl/inst_mem_responder.sv
// inst_mem_responder: instruction memory serving fetch-stage word reads with a
// fixed LATENCY-deep response pipeline, plus a boot-load write port.
//
// Optional feature: define INST_MEM_FAULT_EN to fault misaligned or
// out-of-range reads (response fault=1, data NOP). Without it, address bits
// [1:0] are ignored and the word index wraps modulo DEPTH_WORDS.
//
// Ports:
//   clk, reset (async, active-low)
//   inst_mem_read_req / inst_mem_address   : one read request per cycle
//   flush                                  : kill older in-flight responses
//   inst_mem_is_valid / inst_mem_read_data : response strobe and word
//   inst_mem_fault                         : faulted response (with valid)
//   inflight_count                         : accepted, unreturned requests
//   load_en / load_addr / load_data        : boot-load word write
module inst_mem_responder #(
   parameter logic [31:0] RESET       = 32'h0000_0000,
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned LATENCY     = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_mem_read_req,
   input  logic [31:0] inst_mem_address,
   input  logic        flush,
   output logic        inst_mem_is_valid,
   output logic [31:0] inst_mem_read_data,
   output logic        inst_mem_fault,
   output logic [2:0]  inflight_count,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data
);

   localparam int unsigned AW  = $clog2(DEPTH_WORDS);
   localparam logic [31:0] NOP = 32'h0000_0013;

   // Elaboration-time parameter legality
   if ((LATENCY < 1) || (LATENCY > 4)) begin : g_bad_latency
      $error("inst_mem_responder: LATENCY must be in 1..4");
   end
   if ((DEPTH_WORDS < 16) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
      $error("inst_mem_responder: DEPTH_WORDS must be a power of two >= 16");
   end

   logic [31:0]   mem [DEPTH_WORDS];

   logic [31:0]   rd_off;
   logic [31:0]   ld_off;
   logic [AW-1:0] rd_idx;
   logic [AW-1:0] ld_idx;
   logic          ld_in_range_c;
   logic          rd_fault_c;
   logic          unused_c;

   // Byte offsets from the base; the subtraction wraps mod 2^32
   assign rd_off        = inst_mem_address - RESET;
   assign ld_off        = load_addr - RESET;
   assign rd_idx        = rd_off[AW+1:2];
   assign ld_idx        = ld_off[AW+1:2];
   assign ld_in_range_c = ({2'b00, ld_off[31:2]} < 32'(DEPTH_WORDS));
   assign unused_c      = ^{rd_off, ld_off};

`ifdef INST_MEM_FAULT_EN
   assign rd_fault_c = (rd_off[1:0] != 2'b00) ||
                       ({2'b00, rd_off[31:2]} >= 32'(DEPTH_WORDS));
`else
   assign rd_fault_c = 1'b0;
`endif

   // Boot-load writes; out-of-range loads are dropped, never wrapped
   always_ff @(posedge clk) begin
      if (load_en && ld_in_range_c) begin
         mem[ld_idx] <= load_data;
      end
   end

   logic [LATENCY-1:0] st_valid;
   logic [LATENCY-1:0] st_fault;
   logic [31:0]        st_data [LATENCY];
   logic [2:0]         inflight_nxt;

   // Flush empties the pipeline; a request in the same cycle still enters it
   always_comb begin
      inflight_nxt = inflight_count;
      if (flush) begin
         inflight_nxt = 3'(inst_mem_read_req);
      end else begin
         inflight_nxt = inflight_count - 3'(st_valid[LATENCY-1]) + 3'(inst_mem_read_req);
      end
   end

   // Response pipeline: stage 0 reads the array (old word on same-cycle load),
   // later stages delay. Data only advances with a valid entry so the output
   // word holds between responses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_valid       <= '0;
         st_fault       <= '0;
         inflight_count <= 3'd0;
         for (int i = 0; i < int'(LATENCY); i++) begin
            st_data[i] <= NOP;
         end
      end else begin
         st_valid[0] <= inst_mem_read_req;
         st_fault[0] <= inst_mem_read_req & rd_fault_c;
         if (inst_mem_read_req) begin
            st_data[0] <= rd_fault_c ? NOP : mem[rd_idx];
         end
         for (int i = 1; i < int'(LATENCY); i++) begin
            st_valid[i] <= st_valid[i-1] & ~flush;
            st_fault[i] <= st_fault[i-1] & st_valid[i-1] & ~flush;
            if (st_valid[i-1] && !flush) begin
               st_data[i] <= st_data[i-1];
            end
         end
         inflight_count <= inflight_nxt;
      end
   end

   assign inst_mem_is_valid  = st_valid[LATENCY-1];
   assign inst_mem_fault     = st_fault[LATENCY-1];
   assign inst_mem_read_data = st_data[LATENCY-1];

endmodule

// File: doc/inst_mem_responder.md
# inst_mem_responder

Instruction-memory responder serving the fetch stage's instruction read interface. It accepts one word-read request per cycle and returns the word after a fixed `LATENCY` cycles on `inst_mem_is_valid` / `inst_mem_read_data`. It also provides a boot-load write port for filling the array before or during execution. It sits between the fetch/decode stage and the instruction storage array.

## Interface
Parameters:
- `RESET`, default `32'h0000_0000`: byte address of word 0; matches the core reset PC.
- `DEPTH_WORDS`, default `4096`: array size in 32-bit words; must be a power of two, ≥ 16.
- `LATENCY`, default `1`: request-to-response cycles; legal range 1..4, any other value is an elaboration error.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `inst_mem_read_req`  in  1  read request, sampled each cycle.
- `inst_mem_address`  in  32  byte address of the request.
- `flush`  in  1  kills all in-flight responses (fetch redirect).
- `inst_mem_is_valid`  out  1  response strobe, one cycle per accepted request.
- `inst_mem_read_data`  out  32  response word.
- `inst_mem_fault`  out  1  response is a faulted access; qualified by `inst_mem_is_valid`.
- `inflight_count`  out  3  number of accepted, unreturned requests (0..LATENCY).
- `load_en`  in  1  boot-load write strobe.
- `load_addr`  in  32  byte address of the write.
- `load_data`  in  32  word to write.

## Operation
- No backpressure: every cycle with `inst_mem_read_req=1` is accepted.
- Word index = (`inst_mem_address` − `RESET`) >> 2, computed with 32-bit unsigned subtraction.
- Response pipeline is `LATENCY` deep. Each stage holds a valid bit, a fault bit, and data.
  - The array read occurs in stage 1.
  - Later stages are pure delay.
- `inst_mem_read_data` holds its last value when `inst_mem_is_valid=0`.
- Faulted responses return NOP (`32'h0000_0013`).
- `flush=1` clears every stage's valid bit in the same edge.
  - A request presented in the same cycle as `flush` is still accepted; flush clears only older requests.
- `inflight_count` increments on accept, decrements on response, and is reduced to 0 or 1 by `flush`.
  - It is never negative and never exceeds `LATENCY`.
- Load port:
  - On `load_en=1`, `load_data` is written at the word index of `load_addr`. `load_addr[1:0]` is ignored.
  - Out-of-range loads are dropped; they never wrap.
- Same-cycle load and read to the same word: the read returns the old word (read-before-write). The next read returns the new word.
- The array is not reset. Contents are undefined until loaded.

## Timing
- Reset asserted (asynchronous):
  - `inst_mem_is_valid=0`, `inst_mem_fault=0`, `inflight_count=0`, `inst_mem_read_data=32'h0000_0013`.
  - All pipeline valid bits are cleared.
- Reset mid-operation drops all in-flight responses; none emerge after release.
- A request at edge N produces `inst_mem_is_valid=1` for exactly one cycle after edge N+LATENCY−1, i.e. visible in cycle N+LATENCY.
- Back-to-back requests give back-to-back responses, in order, with no bubbles.
- Load writes commit at the edge where `load_en=1`.

## Configuration
- `INST_MEM_FAULT_EN` defined:
  - Any request with `inst_mem_address[1:0]≠0`, or with word index ≥ `DEPTH_WORDS`, is faulted: the response carries `inst_mem_fault=1` and data NOP.
  - The index wraps mod 2^32, so addresses below `RESET` are out of range.
- `INST_MEM_FAULT_EN` undefined:
  - `inst_mem_fault` is tied 0.
  - Address bits [1:0] are ignored.
  - The word index is truncated to log2(`DEPTH_WORDS`) bits, so accesses wrap modulo the array size.

## Test plan
- Reset, load words 0..3 with `32'h00A00093`, `32'h00108113`, `32'h002081B3`, `32'h0000006F`; request addresses `RESET`+0, +4, +8, +12 back-to-back with `LATENCY=2` → valid in cycles 2..5 with those words in order; `inflight_count` peaks at 2 and returns to 0.
- Request `RESET`+4, then assert `flush` the next cycle together with a new request for `RESET`+8 (`LATENCY=3`) → only the `RESET`+8 response appears; `inflight_count`=1 after the flush.
- Load `RESET`+8 = `32'hDEADBEEF` in the same cycle as a read of `RESET`+8 holding `32'h00000013` → the read returns `32'h00000013`; an immediate re-read returns `32'hDEADBEEF`.
- `INST_MEM_FAULT_EN`: request `RESET`+2, `RESET`+4·`DEPTH_WORDS`, and `RESET`−4 → three responses with `inst_mem_fault=1` and data `32'h00000013`. Without the macro, `RESET`+4·`DEPTH_WORDS` returns word 0 with fault 0.
- Assert `reset` while 3 requests are in flight (`LATENCY=4`) → outputs take reset values immediately; no valid appears after release until a new request is made.
- Idle 10 cycles after a response of `32'h00208113` → `inst_mem_read_data` holds `32'h00208113` and `inst_mem_is_valid` stays 0.
